// File: rtl/pipe_stage_chain.sv
// Purpose : chain of NSTAGES payload/valid pipeline registers with central stall, flush, bubble insert.
// Latency : in_data captured on edge n is visible on stage k after edge n+k; 1 transfer/cycle unstalled.
// Backpr. : a stall on stage k holds stages 0..k; stall_out (= hold of stage 0) freezes fetch combinationally.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   in_data/in_valid  payload and valid from fetch into stage 0
//   stall_vec         per-stage hold request (bit k holds stage k and everything upstream)
//   flush_vec         per-stage flush (stage becomes a bubble, beats hold)
//   cnt_clr           synchronous clear of both event counters
//   out_data          stage k payload at [k*WIDTH +: WIDTH]
//   out_valid         per-stage valid bit
//   stall_out         fetch/PC must hold this cycle
//   bubble_cnt        saturating count of cycles with at least one stall bubble inserted
//   flush_cnt         saturating count of cycles with any flush bit set
module pipe_stage_chain #(
  parameter int               WIDTH        = 300,
  parameter int               NSTAGES      = 4,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0,
  parameter int               CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  input  logic [NSTAGES-1:0]         stall_vec,
  input  logic [NSTAGES-1:0]         flush_vec,
  input  logic                       cnt_clr,
  output logic [NSTAGES*WIDTH-1:0]   out_data,
  output logic [NSTAGES-1:0]         out_valid,
  output logic                       stall_out,
  output logic [CNT_W-1:0]           bubble_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  logic [WIDTH-1:0]   data_q [NSTAGES];
  logic [WIDTH-1:0]   data_d [NSTAGES];
  logic [NSTAGES-1:0] valid_q;
  logic [NSTAGES-1:0] valid_d;
  logic [NSTAGES-1:0] hold;
  logic [NSTAGES-1:1] bub_ins;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  // A stage holds if it or any downstream stage is stalled; written as a
  // shift-and-reduce so there is no combinational self-dependency in hold.
  always_comb begin
    hold = '0;
    for (int k = 0; k < NSTAGES; k++) begin
      hold[k] = |(stall_vec >> k);
    end
  end

  assign stall_out = hold[0];

  // Next-state per stage, rules in priority order: flush, hold, bubble, advance.
  always_comb begin
    for (int k = 0; k < NSTAGES; k++) begin
      data_d[k]  = data_q[k];
      valid_d[k] = valid_q[k];
    end
    bub_ins = '0;

    // Stage 0 is fed from fetch; it never receives a stall bubble.
    if (flush_vec[0]) begin
      data_d[0]  = BUBBLE_VALUE;
      valid_d[0] = 1'b0;
    end else if (!hold[0]) begin
      data_d[0]  = in_data;
      valid_d[0] = in_valid;
    end

    for (int k = 1; k < NSTAGES; k++) begin
      if (flush_vec[k]) begin
        data_d[k]  = BUBBLE_VALUE;
        valid_d[k] = 1'b0;
      end else if (hold[k]) begin
        data_d[k]  = data_q[k];
        valid_d[k] = valid_q[k];
      end else if (hold[k-1]) begin
        // Upstream is frozen but this stage drains: fill the gap with a bubble.
        data_d[k]  = BUBBLE_VALUE;
        valid_d[k] = 1'b0;
        bub_ins[k] = 1'b1;
      end else begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  // Saturating event counters; clear wins over increment.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (cnt_clr) begin
      bubble_cnt_d = '0;
      flush_cnt_d  = '0;
    end else begin
      if ((|bub_ins) && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
      if ((|flush_vec) && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NSTAGES; k++) begin
        data_q[k] <= BUBBLE_VALUE;
      end
      valid_q      <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      for (int k = 0; k < NSTAGES; k++) begin
        data_q[k] <= data_d[k];
      end
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  for (genvar g = 0; g < NSTAGES; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = data_q[g];
  end

  assign out_valid  = valid_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Purpose : self-checking bench for pipe_stage_chain with a queue-based scoreboard.
// Latency : expected state for each edge is queued before the edge and popped on the following falling edge.
// Backpr. : stall/flush vectors are driven directly; the reference model applies the same hold semantics.
module tb_pipe_stage_chain;

  localparam int W  = 300;
  localparam int NS = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [W-1:0]      in_data;
  logic              in_valid;
  logic [NS-1:0]     stall_vec;
  logic [NS-1:0]     flush_vec;
  logic              cnt_clr;
  logic [NS*W-1:0]   out_data;
  logic [NS-1:0]     out_valid;
  logic              stall_out;
  logic [CW-1:0]     bubble_cnt;
  logic [CW-1:0]     flush_cnt;

  pipe_stage_chain #(
    .WIDTH        (W),
    .NSTAGES      (NS),
    .BUBBLE_VALUE ('0),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .stall_vec  (stall_vec),
    .flush_vec  (flush_vec),
    .cnt_clr    (cnt_clr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .stall_out  (stall_out),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
  );

  typedef struct packed {
    logic [NS-1:0]   v;
    logic [NS*W-1:0] d;
    logic [CW-1:0]   bc;
    logic [CW-1:0]   fc;
    logic            so;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: what each stage should contain, plus event counts.
  logic         mv [NS];
  logic [W-1:0] md [NS];
  int           mbc;
  int           mfc;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_payload();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      mv[k] = 1'b0;
      md[k] = '0;
    end
    mbc = 0;
    mfc = 0;
  endtask

  // Drive one cycle's inputs, advance the model by one edge, queue the expectation.
  task automatic apply(input logic [W-1:0] d, input logic v, input logic [NS-1:0] st,
                       input logic [NS-1:0] fl, input logic clr);
    logic         held [NS];
    logic         nv   [NS];
    logic [W-1:0] nd   [NS];
    bit           bub;
    snap_t        s;
    in_data   = d;
    in_valid  = v;
    stall_vec = st;
    flush_vec = fl;
    cnt_clr   = clr;
    for (int k = 0; k < NS; k++) begin
      held[k] = 1'b0;
      for (int j = k; j < NS; j++) if (st[j]) held[k] = 1'b1;
    end
    bub = 0;
    for (int k = 0; k < NS; k++) begin
      if (fl[k]) begin
        nv[k] = 1'b0; nd[k] = '0;
      end else if (held[k]) begin
        nv[k] = mv[k]; nd[k] = md[k];
      end else if (k == 0) begin
        nv[k] = v; nd[k] = d;
      end else if (held[k-1]) begin
        nv[k] = 1'b0; nd[k] = '0; bub = 1;
      end else begin
        nv[k] = mv[k-1]; nd[k] = md[k-1];
      end
    end
    if (clr) begin
      mbc = 0;
      mfc = 0;
    end else begin
      if (bub && mbc < CMAX) mbc++;
      if ((fl != 0) && mfc < CMAX) mfc++;
    end
    for (int k = 0; k < NS; k++) begin
      mv[k] = nv[k];
      md[k] = nd[k];
      s.v[k] = nv[k];
      s.d[k*W +: W] = nd[k];
    end
    s.bc = CW'(mbc);
    s.fc = CW'(mfc);
    s.so = held[0];
    exp_q.push_back(s);
    #1;
  endtask

  // Inputs change one unit after the falling edge, well away from the rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic cycle(input logic [W-1:0] d, input logic v, input logic [NS-1:0] st,
                       input logic [NS-1:0] fl, input logic clr);
    apply(d, v, st, fl, clr);
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, W'(out_valid), W'(0));
    for (int k = 0; k < NS; k++) chk($sformatf("%s_data%0d", tag, k), out_data[k*W +: W], '0);
    chk({tag, "_bubble_cnt"}, W'(bubble_cnt), W'(0));
    chk({tag, "_flush_cnt"}, W'(flush_cnt), W'(0));
    chk({tag, "_stall_out"}, W'(stall_out), W'(0));
  endtask

  // Monitor: compares the DUT against the queued expectation after every edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        snap_t s;
        s = exp_q.pop_front();
        chk("sb_valid", W'(out_valid), W'(s.v));
        chk("sb_stall_out", W'(stall_out), W'(s.so));
        chk("sb_bubble_cnt", W'(bubble_cnt), W'(s.bc));
        chk("sb_flush_cnt", W'(flush_cnt), W'(s.fc));
        for (int k = 0; k < NS; k++)
          chk($sformatf("sb_data%0d", k), out_data[k*W +: W], s.d[k*W +: W]);
      end
    end
  end

  initial begin
    rst = 1'b0; in_data = '0; in_valid = 1'b0;
    stall_vec = '0; flush_vec = '0; cnt_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("init");
    rst = 1'b1;

    // T1: random preload, then asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 30; i++)
      cycle(rand_payload(), 1'($urandom), ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0,
            ($urandom_range(0, 4) == 0) ? NS'($urandom) : '0, 1'b0);
    stall_vec = '0; flush_vec = '0; in_valid = 1'b0; cnt_clr = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_state("t1_async");
    tick();
    check_reset_state("t1_held");
    model_reset();
    rst = 1'b1;

    // T2: stream 1..5, stage 3 shows 1 after the 4th edge then 2..5.
    for (int i = 1; i <= 8; i++) begin
      cycle((i <= 5) ? W'(i) : '0, (i <= 5), '0, '0, 1'b0);
      if (i >= 4) begin
        chk($sformatf("t2_stage3_data_e%0d", i), out_data[3*W +: W], W'(i - 3));
        chk($sformatf("t2_stage3_valid_e%0d", i), W'(out_valid[3]), W'(1));
      end
    end

    // T3: load-use stall on stage 0.
    cycle(W'(7), 1'b1, '0, '0, 1'b1);
    apply(W'(99), 1'b1, 4'b0001, '0, 1'b0);
    chk("t3_stall_out", W'(stall_out), W'(1));
    tick();
    chk("t3_stage0_data", out_data[0 +: W], W'(7));
    chk("t3_stage0_valid", W'(out_valid[0]), W'(1));
    chk("t3_stage1_valid", W'(out_valid[1]), W'(0));
    chk("t3_bubble_cnt", W'(bubble_cnt), W'(1));
    cycle('0, 1'b0, '0, '0, 1'b0);
    chk("t3_stage1_data", out_data[W +: W], W'(7));
    chk("t3_stage1_valid_next", W'(out_valid[1]), W'(1));

    // T4: branch redirect flushes stages 0 and 1.
    cycle(W'(10), 1'b1, '0, '0, 1'b0);
    cycle(W'(9), 1'b1, '0, '0, 1'b0);
    cycle(W'(8), 1'b1, '0, '0, 1'b1);
    cycle(W'(55), 1'b1, '0, 4'b0011, 1'b0);
    chk("t4_stage0_valid", W'(out_valid[0]), W'(0));
    chk("t4_stage0_data", out_data[0 +: W], '0);
    chk("t4_stage1_valid", W'(out_valid[1]), W'(0));
    chk("t4_stage2_data", out_data[2*W +: W], W'(9));
    chk("t4_stage3_data", out_data[3*W +: W], W'(10));
    chk("t4_flush_cnt", W'(flush_cnt), W'(1));

    // T5: stall and flush on the same stage.
    cycle(W'(21), 1'b1, '0, '0, 1'b0);
    cycle(W'(22), 1'b1, '0, '0, 1'b0);
    cycle(W'(23), 1'b1, '0, '0, 1'b0);
    cycle(W'(24), 1'b1, '0, '0, 1'b0);
    apply(W'(77), 1'b1, 4'b0100, 4'b0100, 1'b0);
    chk("t5_stall_out", W'(stall_out), W'(1));
    tick();
    chk("t5_stage0_data", out_data[0 +: W], W'(24));
    chk("t5_stage1_data", out_data[W +: W], W'(23));
    chk("t5_stage2_valid", W'(out_valid[2]), W'(0));
    chk("t5_stage2_data", out_data[2*W +: W], '0);
    chk("t5_stage3_valid", W'(out_valid[3]), W'(0));

    // T6: bubble counter saturation and clear.
    cycle('0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(rand_payload(), 1'b1, 4'b0001, '0, 1'b0);
    chk("t6_bubble_sat", W'(bubble_cnt), W'(CMAX));
    cycle(rand_payload(), 1'b1, 4'b0001, '0, 1'b1);
    chk("t6_bubble_clr", W'(bubble_cnt), W'(0));

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++)
      cycle(rand_payload(), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0,
            ($urandom_range(0, 5) == 0) ? NS'($urandom) : '0,
            ($urandom_range(0, 40) == 0));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
